adc_spi_cfg_ctrl: RTL and testbench

//  Power-up sequencer and serial-interface master for the dual-channel 14-bit DDR ADC.
//  - Pulses the ADC reset pin, then writes a fixed register table over the 3-wire serial port.
//  - Afterwards serves run-time single-register writes from system logic.
//  - Drives adc_reset_out/adc_sclk_out/adc_sdata_out/adc_sen_out, which are otherwise tied off in the ADC driver.

---
 rtl/adc_spi_cfg_ctrl_if.sv | 50 +++++
 rtl/adc_spi_cfg_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_adc_spi_cfg_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_cfg_ctrl_if.sv
// ---------------------------------------------------------------------------
// adc_spi_cfg_ctrl_if
// System-side control bundle of the ADC configuration controller.
//   init_start  : pulse, (re)run the ADC reset pulse and the full register table
//   wr_req      : level request for a run-time register write, held until wr_ack
//   wr_addr     : run-time register address
//   wr_data     : run-time register data
//   wr_ack      : one-cycle pulse when the run-time frame has completed
//   busy        : controller is not idle
//   cfg_done    : the init table has been completely sent
//   rd_data     : byte read back from the ADC (ADC_SPI_READBACK_EN only)
//   rd_valid    : rd_data update strobe (ADC_SPI_READBACK_EN only)
// Modports: master = system logic, slave = controller.
// Optional feature macro: ADC_SPI_READBACK_EN
// ---------------------------------------------------------------------------
interface adc_spi_cfg_ctrl_if;
  logic       init_start;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       busy;
  logic       cfg_done;
`ifdef ADC_SPI_READBACK_EN
  logic [7:0] rd_data;
  logic       rd_valid;
`endif

`ifdef ADC_SPI_READBACK_EN
  modport master (
    output init_start, wr_req, wr_addr, wr_data,
    input  wr_ack, busy, cfg_done, rd_data, rd_valid
  );

  modport slave (
    input  init_start, wr_req, wr_addr, wr_data,
    output wr_ack, busy, cfg_done, rd_data, rd_valid
  );
`else
  modport master (
    output init_start, wr_req, wr_addr, wr_data,
    input  wr_ack, busy, cfg_done
  );

  modport slave (
    input  init_start, wr_req, wr_addr, wr_data,
    output wr_ack, busy, cfg_done
  );
`endif
endinterface

// File: rtl/adc_spi_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// adc_spi_cfg_ctrl
// Power-up sequencer and 3-wire serial master for the dual-channel 14-bit
// DDR ADC. After reset (or on init_start) it pulses the ADC reset pin, waits,
// then writes a fixed table of {addr,data} words. Afterwards it serves
// single-register writes requested by system logic.
//
// Ports
//   clk           : system clock, rising edge
//   rst           : synchronous, active-low reset
//   bus           : adc_spi_cfg_ctrl_if.slave (init_start, wr_req/addr/data,
//                   wr_ack, busy, cfg_done [, rd_data, rd_valid])
//   adc_reset_out : ADC hardware reset, active-high
//   adc_sclk_out  : serial clock, idles low
//   adc_sdata_out : serial data, MSB first, changes at SCLK low-phase start
//   adc_sen_out   : serial enable, active-low
//   adc_sdout_in  : ADC serial readout, used only with ADC_SPI_READBACK_EN
//
// Optional feature macro: ADC_SPI_READBACK_EN
//   Captures adc_sdout_in during the eight data bits of each frame into
//   bus.rd_data and strobes bus.rd_valid at the end of every frame.
//
// Frame shape: the LOAD cycle is the first cycle of bit 15's low phase, so
// SEN stays low for CLK_DIV*33 cycles and frames repeat every CLK_DIV*34.
// All pin and status outputs are registered from the next-state values so
// they line up exactly with the state they belong to.
// ---------------------------------------------------------------------------
module adc_spi_cfg_ctrl #(
  parameter int                     CLK_DIV       = 4,
  parameter int                     RST_PULSE_CYC = 16,
  parameter int                     RST_WAIT_CYC  = 256,
  parameter int                     NUM_REGS      = 4,
  parameter logic [NUM_REGS*16-1:0] INIT_TABLE    = '0,
  parameter int                     AUTO_INIT     = 1
) (
  input  logic                clk,
  input  logic                rst,
  adc_spi_cfg_ctrl_if.slave   bus,
  output logic                adc_reset_out,
  output logic                adc_sclk_out,
  output logic                adc_sdata_out,
  output logic                adc_sen_out,
  input  logic                adc_sdout_in
);

  // One shared counter covers the reset pulse, the post-reset wait and the
  // SCLK half-periods; it is sized for the longest of them.
  localparam int CNT_MAX0 = (RST_PULSE_CYC > RST_WAIT_CYC) ? RST_PULSE_CYC : RST_WAIT_CYC;
  localparam int CNT_MAX  = ((CNT_MAX0 > CLK_DIV) ? CNT_MAX0 : CLK_DIV) - 1;
  localparam int CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RST_PULSE,
    RST_WAIT,
    LOAD,
    SHIFT,
    TAIL,
    GAP
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [3:0]         bit_idx, bit_nxt;
  logic               sclk_hi, sclk_hi_nxt;
  logic [15:0]        word, word_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               runtime, runtime_nxt;
  logic               auto_pending, auto_nxt;
  logic               cfg_done_r, cfg_done_nxt;
  logic               reset_r, reset_nxt;
  logic               sclk_r, sclk_nxt;
  logic               sdata_r, sdata_nxt;
  logic               sen_r, sen_nxt;
  logic               busy_r, busy_nxt;
  logic               ack_r, ack_nxt;
  logic               frame_end_nxt;

`ifdef ADC_SPI_READBACK_EN
  logic [7:0]         rd_shift, rd_shift_nxt;
  logic [7:0]         rd_data_r, rd_data_nxt;
  logic               rd_valid_r, rd_valid_nxt;
`else
  logic               unused_sdout;
  assign unused_sdout = adc_sdout_in;
`endif

  // Constant-index lookup into the flattened init table.
  function automatic logic [15:0] table_entry(input logic [IDX_W-1:0] sel);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == IDX_W'(i)) w = INIT_TABLE[16*i +: 16];
    end
    return w;
  endfunction

  // State register plus registered outputs; rst is sampled on the clock and
  // abandons any frame in flight without a completion pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= 4'd15;
      sclk_hi      <= 1'b0;
      word         <= '0;
      idx          <= '0;
      runtime      <= 1'b0;
      auto_pending <= (AUTO_INIT != 0);
      cfg_done_r   <= 1'b0;
      reset_r      <= 1'b0;
      sclk_r       <= 1'b0;
      sdata_r      <= 1'b0;
      sen_r        <= 1'b1;
      busy_r       <= 1'b0;
      ack_r        <= 1'b0;
`ifdef ADC_SPI_READBACK_EN
      rd_shift     <= '0;
      rd_data_r    <= '0;
      rd_valid_r   <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_idx      <= bit_nxt;
      sclk_hi      <= sclk_hi_nxt;
      word         <= word_nxt;
      idx          <= idx_nxt;
      runtime      <= runtime_nxt;
      auto_pending <= auto_nxt;
      cfg_done_r   <= cfg_done_nxt;
      reset_r      <= reset_nxt;
      sclk_r       <= sclk_nxt;
      sdata_r      <= sdata_nxt;
      sen_r        <= sen_nxt;
      busy_r       <= busy_nxt;
      ack_r        <= ack_nxt;
`ifdef ADC_SPI_READBACK_EN
      rd_shift     <= rd_shift_nxt;
      rd_data_r    <= rd_data_nxt;
      rd_valid_r   <= rd_valid_nxt;
`endif
    end
  end

  // Next-state logic. The word to shift is latched on the edge that enters
  // LOAD, so bit 15 is already on the data pin during the LOAD cycle.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bit_nxt       = bit_idx;
    sclk_hi_nxt   = sclk_hi;
    word_nxt      = word;
    idx_nxt       = idx;
    runtime_nxt   = runtime;
    auto_nxt      = auto_pending;
    cfg_done_nxt  = cfg_done_r;
    frame_end_nxt = 1'b0;

    case (state)
      IDLE: begin
        // init_start beats a simultaneous wr_req, which simply stays pending.
        if (bus.init_start || auto_pending) begin
          state_nxt    = RST_PULSE;
          cnt_nxt      = '0;
          auto_nxt     = 1'b0;
          cfg_done_nxt = 1'b0;
        end else if (bus.wr_req && cfg_done_r) begin
          state_nxt   = LOAD;
          runtime_nxt = 1'b1;
          word_nxt    = {bus.wr_addr, bus.wr_data};
          bit_nxt     = 4'd15;
          sclk_hi_nxt = 1'b0;
          cnt_nxt     = '0;
        end
      end

      RST_PULSE: begin
        if (cnt == CNT_W'(RST_PULSE_CYC - 1)) begin
          state_nxt = RST_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      RST_WAIT: begin
        if (cnt == CNT_W'(RST_WAIT_CYC - 1)) begin
          state_nxt   = LOAD;
          idx_nxt     = '0;
          runtime_nxt = 1'b0;
          word_nxt    = table_entry('0);
          bit_nxt     = 4'd15;
          sclk_hi_nxt = 1'b0;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      LOAD: begin
        // LOAD already counts as the first cycle of bit 15's low phase.
        state_nxt = SHIFT;
        if (CLK_DIV == 1) begin
          sclk_hi_nxt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          sclk_hi_nxt = 1'b0;
          cnt_nxt     = CNT_W'(1);
        end
      end

      SHIFT: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cnt_nxt = '0;
          if (!sclk_hi) begin
            sclk_hi_nxt = 1'b1;
          end else if (bit_idx == 4'd0) begin
            state_nxt   = TAIL;
            sclk_hi_nxt = 1'b0;
          end else begin
            bit_nxt     = bit_idx - 4'd1;
            sclk_hi_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      TAIL: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cnt_nxt = '0;
          if (runtime) begin
            state_nxt = IDLE;
          end else if (idx == IDX_W'(NUM_REGS - 1)) begin
            state_nxt    = IDLE;
            cfg_done_nxt = 1'b1;
          end else begin
            idx_nxt     = idx + IDX_W'(1);
            word_nxt    = table_entry(idx + IDX_W'(1));
            state_nxt   = LOAD;
            bit_nxt     = 4'd15;
            sclk_hi_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // The last GAP cycle is the frame's exit cycle; acks are visible there,
    // so busy falls on the very next cycle.
    frame_end_nxt = (state_nxt == GAP) && (cnt_nxt == CNT_W'(CLK_DIV - 1));
    ack_nxt       = frame_end_nxt && runtime_nxt;

    reset_nxt = (state_nxt == RST_PULSE);
    sen_nxt   = !((state_nxt == LOAD) || (state_nxt == SHIFT) || (state_nxt == TAIL));
    sclk_nxt  = (state_nxt == SHIFT) && sclk_hi_nxt;
    sdata_nxt = ((state_nxt == LOAD) || (state_nxt == SHIFT)) ? word_nxt[bit_nxt] : 1'b0;
    busy_nxt  = (state_nxt != IDLE);
  end

`ifdef ADC_SPI_READBACK_EN
  // The ADC read line is sampled at the end of the first SCLK-high cycle of
  // each data bit (bits 7..0) and the byte is published at frame exit.
  always_comb begin
    rd_shift_nxt = rd_shift;
    rd_data_nxt  = rd_data_r;
    rd_valid_nxt = frame_end_nxt;
    if ((state == SHIFT) && sclk_hi && (cnt == '0) && (bit_idx <= 4'd7)) begin
      rd_shift_nxt = {rd_shift[6:0], adc_sdout_in};
    end
    if (frame_end_nxt) begin
      rd_data_nxt = rd_shift_nxt;
    end
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
`endif

  assign bus.wr_ack    = ack_r;
  assign bus.busy      = busy_r;
  assign bus.cfg_done  = cfg_done_r;
  assign adc_reset_out = reset_r;
  assign adc_sclk_out  = sclk_r;
  assign adc_sdata_out = sdata_r;
  assign adc_sen_out   = sen_r;

endmodule

// File: tb/tb_adc_spi_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_cfg_ctrl
// Bench for adc_spi_cfg_ctrl with CLK_DIV=2, RST_PULSE_CYC=4, RST_WAIT_CYC=8,
// NUM_REGS=2, table {0x441A, 0x0002}. A pin-level serial monitor rebuilds each
// frame from the SCLK rises and measures reset and SEN timing; the expected
// frame order is kept as a queue of words derived from the init/write rules.
// Readback checks are compiled in when ADC_SPI_READBACK_EN is defined.
// ---------------------------------------------------------------------------
module tb_adc_spi_cfg_ctrl;

  localparam int CLK_DIV       = 2;
  localparam int RST_PULSE_CYC = 4;
  localparam int RST_WAIT_CYC  = 8;
  localparam int NUM_REGS      = 2;
  localparam logic [31:0] INIT_TABLE = {16'h441A, 16'h0002};
  localparam int SEN_LOW_CYC   = CLK_DIV * 33;
  localparam int LIMIT         = 2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic adc_reset_out, adc_sclk_out, adc_sdata_out, adc_sen_out;
  logic adc_sdout_in = 1'b0;

  adc_spi_cfg_ctrl_if bus ();

  adc_spi_cfg_ctrl #(
    .CLK_DIV       (CLK_DIV),
    .RST_PULSE_CYC (RST_PULSE_CYC),
    .RST_WAIT_CYC  (RST_WAIT_CYC),
    .NUM_REGS      (NUM_REGS),
    .INIT_TABLE    (INIT_TABLE),
    .AUTO_INIT     (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .adc_reset_out (adc_reset_out),
    .adc_sclk_out  (adc_sclk_out),
    .adc_sdata_out (adc_sdata_out),
    .adc_sen_out   (adc_sen_out),
    .adc_sdout_in  (adc_sdout_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected serial traffic, in order.
  logic [15:0] exp_frames [$];
  logic [15:0] table_words [NUM_REGS] = '{16'h0002, 16'h441A};

  // Monitor state.
  int          cyc = 0;
  int          rst_run = 0;
  int          rst_len_last = 0;
  int          rst_fall_cyc = 0;
  int          gap_after_rst = -1;
  bit          armed_gap = 1'b0;
  int          pulse_count = 0;
  int          sen_cnt = 0;
  int          bits = 0;
  int          ack_count = 0;
  logic        ack_cfg_done = 1'b0;
  logic        prev_sclk = 1'b0;
  logic        prev_sen = 1'b1;
  logic        prev_reset = 1'b0;
  logic [15:0] shreg = '0;
  logic [15:0] frames [$];
  int          lens [$];
  int          bitcnts [$];
  logic [7:0]  rb_pattern = 8'h00;

  // Pin-level observer: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    int cur;
    cyc++;
    if (!rst) begin
      bits       = 0;
      sen_cnt    = 0;
      rst_run    = 0;
      prev_sclk  = 1'b0;
      prev_sen   = 1'b1;
      prev_reset = 1'b0;
    end else begin
      if (adc_reset_out) rst_run++;
      if (prev_reset && !adc_reset_out) begin
        rst_len_last = rst_run;
        rst_run      = 0;
        rst_fall_cyc = cyc;
        armed_gap    = 1'b1;
        pulse_count++;
      end
      if (!adc_sen_out) begin
        if (prev_sen && armed_gap) begin
          gap_after_rst = cyc - rst_fall_cyc;
          armed_gap     = 1'b0;
        end
        sen_cnt++;
        if (adc_sclk_out && !prev_sclk) begin
          shreg = {shreg[14:0], adc_sdata_out};
          bits++;
        end
      end
      if (adc_sen_out && !prev_sen) begin
        frames.push_back(shreg);
        lens.push_back(sen_cnt);
        bitcnts.push_back(bits);
        bits    = 0;
        sen_cnt = 0;
      end
      if (bus.wr_ack) begin
        ack_count++;
        ack_cfg_done = bus.cfg_done;
      end
      prev_sclk  = adc_sclk_out;
      prev_sen   = adc_sen_out;
      prev_reset = adc_reset_out;
    end
`ifdef ADC_SPI_READBACK_EN
    // Present the readback byte during data bits (frame bit positions 8..15).
    cur = adc_sclk_out ? bits - 1 : bits;
    if (!adc_sen_out && cur >= 8 && cur <= 15) adc_sdout_in = rb_pattern[15 - cur];
    else adc_sdout_in = 1'b0;
`else
    cur = 0;
    adc_sdout_in = 1'($urandom_range(0, 1)) ^ 1'(cur);
`endif
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic init, input logic req, input logic [7:0] addr,
                                input logic [7:0] data);
    bus.init_start = init;
    bus.wr_req     = req;
    bus.wr_addr    = addr;
    bus.wr_data    = data;
  endtask

  task automatic model_init();
    for (int i = 0; i < NUM_REGS; i++) exp_frames.push_back(table_words[i]);
  endtask

  task automatic wait_cfg_done(input string tag);
    int n = 0;
    while (bus.cfg_done !== 1'b1 && n < LIMIT) begin
      step_cycle();
      n++;
    end
    check_output(tag, 32'(bus.cfg_done), 32'd1);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (bus.wr_ack !== 1'b1 && n < LIMIT) begin
      step_cycle();
      n++;
    end
    check_output(tag, 32'(bus.wr_ack), 32'd1);
  endtask

  task automatic compare_frames(input string tag);
    check_output({tag, "_count"}, 32'(frames.size()), 32'(exp_frames.size()));
    for (int i = 0; i < exp_frames.size() && i < frames.size(); i++) begin
      check_output($sformatf("%s_word%0d", tag, i), 32'(frames[i]), 32'(exp_frames[i]));
      check_output($sformatf("%s_senlen%0d", tag, i), 32'(lens[i]), 32'(SEN_LOW_CYC));
      check_output($sformatf("%s_bits%0d", tag, i), 32'(bitcnts[i]), 32'd16);
    end
    frames.delete();
    lens.delete();
    bitcnts.delete();
    exp_frames.delete();
  endtask

  // Serve one run-time write and verify handshake timing and the frame.
  task automatic run_write(input string tag, input logic [7:0] addr, input logic [7:0] data,
                           input logic [7:0] rb);
    int acks0;
    acks0      = ack_count;
    rb_pattern = rb;
    exp_frames.push_back({addr, data});
    apply_stimulus(1'b0, 1'b1, addr, data);
    wait_ack({tag, "_ack"});
    check_output({tag, "_busy_at_ack"}, 32'(bus.busy), 32'd1);
`ifdef ADC_SPI_READBACK_EN
    check_output({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd1);
    check_output({tag, "_rd_data"}, 32'(bus.rd_data), 32'(rb));
`endif
    apply_stimulus(1'b0, 1'b0, addr, data);
    step_cycle();
    check_output({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    check_output({tag, "_ack_one_pulse"}, 32'(bus.wr_ack), 32'd0);
    check_output({tag, "_ack_count"}, 32'(ack_count - acks0), 32'd1);
    compare_frames(tag);
  endtask

  initial begin
    int pulses0, acks0, n;
    logic [7:0] a, d;

    // Reset state.
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    repeat (3) step_cycle();
    check_output("rst_sen", 32'(adc_sen_out), 32'd1);
    check_output("rst_sclk", 32'(adc_sclk_out), 32'd0);
    check_output("rst_sdata", 32'(adc_sdata_out), 32'd0);
    check_output("rst_adc_reset", 32'(adc_reset_out), 32'd0);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_cfg_done", 32'(bus.cfg_done), 32'd0);
    check_output("rst_ack", 32'(bus.wr_ack), 32'd0);

    // Automatic init after reset release.
    $display("[TB] power-up init");
    rst = 1'b1;
    model_init();
    step_cycle();
    step_cycle();
    check_output("auto_reset_high", 32'(adc_reset_out), 32'd1);
    check_output("auto_cfg_low", 32'(bus.cfg_done), 32'd0);
    wait_cfg_done("init_cfg_done");
    check_output("init_reset_len", 32'(rst_len_last), 32'(RST_PULSE_CYC));
    check_output("init_first_sen_gap", 32'(gap_after_rst), 32'(RST_WAIT_CYC));
    check_output("init_busy", 32'(bus.busy), 32'd0);
    check_output("init_no_ack", 32'(ack_count), 32'd0);
    compare_frames("init");

    // Directed write followed by random writes.
    $display("[TB] run-time writes");
    run_write("wr_3fa5", 8'h3F, 8'hA5, 8'hC3);
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      run_write($sformatf("wr_rand%0d", i), a, d, 8'($urandom));
    end

    // wr_req held during a re-init is served only after cfg_done.
    $display("[TB] write held off during init");
    pulses0 = pulse_count;
    acks0   = ack_count;
    a = 8'($urandom);
    d = 8'($urandom);
    apply_stimulus(1'b1, 1'b0, a, d);
    step_cycle();
    apply_stimulus(1'b0, 1'b1, a, d);
    check_output("held_reset_high", 32'(adc_reset_out), 32'd1);
    check_output("held_cfg_low", 32'(bus.cfg_done), 32'd0);
    model_init();
    exp_frames.push_back({a, d});
    rb_pattern = 8'($urandom);
    wait_ack("held_ack");
    check_output("held_cfg_at_ack", 32'(ack_cfg_done), 32'd1);
    apply_stimulus(1'b0, 1'b0, a, d);
    step_cycle();
    check_output("held_busy_after", 32'(bus.busy), 32'd0);
    check_output("held_ack_count", 32'(ack_count - acks0), 32'd1);
    check_output("held_pulses", 32'(pulse_count - pulses0), 32'd1);
    compare_frames("held");

    // init_start and wr_req together; init_start while busy is ignored.
    $display("[TB] init_start and wr_req collide");
    pulses0 = pulse_count;
    acks0   = ack_count;
    a = 8'($urandom);
    d = 8'($urandom);
    apply_stimulus(1'b1, 1'b1, a, d);
    step_cycle();
    apply_stimulus(1'b0, 1'b1, a, d);
    check_output("both_reset_high", 32'(adc_reset_out), 32'd1);
    check_output("both_cfg_low", 32'(bus.cfg_done), 32'd0);
    n = 0;
    while (adc_sen_out !== 1'b0 && n < LIMIT) begin
      step_cycle();
      n++;
    end
    check_output("both_sen_fall", 32'(adc_sen_out), 32'd0);
    check_output("both_cfg_low_frame", 32'(bus.cfg_done), 32'd0);
    apply_stimulus(1'b1, 1'b1, a, d);
    step_cycle();
    apply_stimulus(1'b0, 1'b1, a, d);
    model_init();
    exp_frames.push_back({a, d});
    rb_pattern = 8'($urandom);
    wait_ack("both_ack");
    apply_stimulus(1'b0, 1'b0, a, d);
    step_cycle();
    check_output("both_ack_count", 32'(ack_count - acks0), 32'd1);
    check_output("both_pulses", 32'(pulse_count - pulses0), 32'd1);
    compare_frames("both");

    // Reset asserted in the middle of a frame at bit 9.
    $display("[TB] reset mid-frame");
    acks0 = ack_count;
    apply_stimulus(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    n = 0;
    while (bits != 7 && n < LIMIT) begin
      step_cycle();
      n++;
    end
    check_output("midrst_reach_bit9", 32'(bits), 32'd7);
    check_output("midrst_sen_low", 32'(adc_sen_out), 32'd0);
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00);
    step_cycle();
    check_output("midrst_sen", 32'(adc_sen_out), 32'd1);
    check_output("midrst_sclk", 32'(adc_sclk_out), 32'd0);
    check_output("midrst_sdata", 32'(adc_sdata_out), 32'd0);
    check_output("midrst_busy", 32'(bus.busy), 32'd0);
    check_output("midrst_cfg", 32'(bus.cfg_done), 32'd0);
    check_output("midrst_ack", 32'(bus.wr_ack), 32'd0);
    step_cycle();
    pulses0 = pulse_count;
    rst = 1'b1;
    model_init();
    wait_cfg_done("midrst_reinit");
    check_output("midrst_no_ack", 32'(ack_count - acks0), 32'd0);
    check_output("midrst_pulses", 32'(pulse_count - pulses0), 32'd1);
    check_output("midrst_reset_len", 32'(rst_len_last), 32'(RST_PULSE_CYC));
    compare_frames("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
